vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_gen_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, sync polarity encodings and the
// per-pixel control bundle carried through the sync/blank delay line.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic blank_n;
    } vid_ctl_t;

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line: DEPTH-stage shift register that advances only when en is
// high; DEPTH=0 degenerates to a straight wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             VGA_clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{VGA_clock, reset, en, rst_val};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge VGA_clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= rst_val;
                end else if (en) begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: column/row/frame counters with undelayed position flags
// and sync/blank outputs re-timed through a pix_en-gated delay line.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_NEG,
    parameter logic VS_POL   = POL_NEG,
    parameter int   PIPE_DLY = 2,
    parameter int   XW       = 10,
    parameter int   YW       = 10,
    parameter int   FCW      = 16
) (
    input  logic           VGA_clock,
    input  logic           reset,
    input  logic           pix_en,
    output logic           h_sync,
    output logic           v_sync,
    output logic           blank_n,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic           active,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_bad_size
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in XW/YW");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be 0..7");
        end
    endgenerate

    // One extra bit so a bound equal to 2^XW / 2^YW still compares correctly.
    localparam logic [XW:0] X_LAST   = (XW+1)'(H_TOTAL - 1);
    localparam logic [XW:0] X_ACT    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] X_HS_BEG = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] X_HS_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] Y_LAST   = (YW+1)'(V_TOTAL - 1);
    localparam logic [YW:0] Y_ACT    = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] Y_VS_BEG = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] Y_VS_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW:0] x_ext;
    logic [YW:0] y_ext;
    logic        x_last, y_last, h_raw, v_raw;
    vid_ctl_t    ctl_raw, ctl_rst, ctl_dly;

    assign x_ext  = {1'b0, x};
    assign y_ext  = {1'b0, y};
    assign x_last = (x_ext == X_LAST);
    assign y_last = (y_ext == Y_LAST);

    always_ff @(posedge VGA_clock) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else if (pix_en) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y           <= '0;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign active      = (x_ext < X_ACT) && (y_ext < Y_ACT);
    assign h_raw       = (x_ext >= X_HS_BEG) && (x_ext < X_HS_END);
    assign v_raw       = (y_ext >= Y_VS_BEG) && (y_ext < Y_VS_END);
    assign line_start  = pix_en && (x == '0);
    assign frame_start = pix_en && (x == '0) && (y == '0);

    assign ctl_raw = '{h_sync: sync_level(h_raw, HS_POL),
                       v_sync: sync_level(v_raw, VS_POL),
                       blank_n: active};
    assign ctl_rst = '{h_sync: ~HS_POL, v_sync: ~VS_POL, blank_n: 1'b0};

    vga_delay_line #(
        .WIDTH(3),
        .DEPTH(PIPE_DLY)
    ) u_delay_line (
        .VGA_clock(VGA_clock),
        .reset    (reset),
        .en       (pix_en),
        .rst_val  (ctl_rst),
        .d        (ctl_raw),
        .q        (ctl_dly)
    );

    assign h_sync  = ctl_dly.h_sync;
    assign v_sync  = ctl_dly.v_sync;
    assign blank_n = ctl_dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configurations driven by shared random
// stimulus, compared against an enabled-cycle-count raster model.
module tb_vga_timing_gen;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb;
        logic hp, vp;
        int   dly, fcw;
    } cfg_t;

    localparam cfg_t CFG_A = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 2, vs: 2, vb: 2,
                              hp: 1'b1, vp: 1'b0, dly: 2, fcw: 2};
    localparam cfg_t CFG_B = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 4, vf: 1, vs: 1, vb: 1,
                              hp: 1'b0, vp: 1'b1, dly: 0, fcw: 16};

    logic VGA_clock = 1'b0;
    logic reset     = 1'b1;
    logic pix_en    = 1'b0;

    logic       a_hs, a_vs, a_bn, a_act, a_ls, a_fs;
    logic [3:0] a_x, a_y;
    logic [1:0] a_fc;
    logic        b_hs, b_vs, b_bn, b_act, b_ls, b_fs;
    logic [9:0]  b_x;
    logic [2:0]  b_y;
    logic [15:0] b_fc;

    int     checks   = 0;
    int     failures = 0;
    longint p        = 0;   // enabled edges since the last reset

    always #5 VGA_clock = ~VGA_clock;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(2),
        .XW(4), .YW(4), .FCW(2)
    ) dut_a (
        .VGA_clock(VGA_clock), .reset(reset), .pix_en(pix_en),
        .h_sync(a_hs), .v_sync(a_vs), .blank_n(a_bn),
        .x(a_x), .y(a_y), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .VS_POL(1'b1), .PIPE_DLY(0), .YW(3)
    ) dut_b (
        .VGA_clock(VGA_clock), .reset(reset), .pix_en(pix_en),
        .h_sync(b_hs), .v_sync(b_vs), .blank_n(b_bn),
        .x(b_x), .y(b_y), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d p=%0d", tag, obs, exp, p);
        end
    endtask

    // {h_sync, v_sync, blank_n} for the raster position reached after q enabled edges
    function automatic logic [2:0] ctl_at(input cfg_t c, input longint q);
        longint ht, vt, cx, cy;
        logic in_hs, in_vs, act;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        cx = q % ht;
        cy = (q / ht) % vt;
        in_hs = (cx >= c.ha + c.hf) && (cx < c.ha + c.hf + c.hs);
        in_vs = (cy >= c.va + c.vf) && (cy < c.va + c.vf + c.vs);
        act   = (cx < c.ha) && (cy < c.va);
        return {in_hs ? c.hp : ~c.hp, in_vs ? c.vp : ~c.vp, act};
    endfunction

    task automatic check_dut(input string tag, input cfg_t c,
                             input logic hs, input logic vs, input logic bn,
                             input int ox, input int oy, input logic act,
                             input logic ls, input logic fs, input int fc);
        longint ht, vt, ex, ey, efc;
        logic [2:0] now_ctl, dly_ctl;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        ex  = p % ht;
        ey  = (p / ht) % vt;
        efc = (p / (ht * vt)) % (longint'(1) << c.fcw);
        now_ctl = ctl_at(c, p);
        if (c.dly == 0)        dly_ctl = now_ctl;
        else if (p < c.dly)    dly_ctl = {~c.hp, ~c.vp, 1'b0};
        else                   dly_ctl = ctl_at(c, p - c.dly);
        chk({tag, ".x"}, ox, int'(ex));
        chk({tag, ".y"}, oy, int'(ey));
        chk({tag, ".frame_count"}, fc, int'(efc));
        chk({tag, ".active"}, int'(act), int'(now_ctl[0]));
        chk({tag, ".line_start"}, int'(ls), int'(pix_en && ex == 0));
        chk({tag, ".frame_start"}, int'(fs), int'(pix_en && ex == 0 && ey == 0));
        chk({tag, ".h_sync"}, int'(hs), int'(dly_ctl[2]));
        chk({tag, ".v_sync"}, int'(vs), int'(dly_ctl[1]));
        chk({tag, ".blank_n"}, int'(bn), int'(dly_ctl[0]));
    endtask

    task automatic cycle(input logic r, input logic e);
        reset  = r;
        pix_en = e;
        @(negedge VGA_clock);
        check_dut("a", CFG_A, a_hs, a_vs, a_bn, int'(a_x), int'(a_y), a_act, a_ls, a_fs, int'(a_fc));
        check_dut("b", CFG_B, b_hs, b_vs, b_bn, int'(b_x), int'(b_y), b_act, b_ls, b_fs, int'(b_fc));
        @(posedge VGA_clock);
        if (r)      p = 0;
        else if (e) p++;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge VGA_clock);
        #1;
        // reset wins regardless of pix_en
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'($urandom_range(0, 1)));
        // free-running: several small frames, frame_count wraps 3->0
        for (int i = 0; i < 2000; i++) cycle(1'b0, 1'b1);
        // alternating enable: counters and pipeline hold on idle cycles
        for (int i = 0; i < 2000; i++) cycle(1'b0, 1'(i % 2 == 0));
        // random enable with occasional mid-frame reset
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0));
        // directed mid-frame reset then resume
        for (int i = 0; i < 337; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        // long enabled run: the larger configuration completes two frames
        for (int i = 0; i < 11400; i++) cycle(1'b0, 1'b1);
        chk("b.two_frames", int'(b_fc), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
